// File: rtl/board_status_pkg.sv
// Shared types and helpers for the board status/LED controller.
package board_status_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    PASS     = 3'd1,
    FAIL_ON  = 3'd2,
    FAIL_OFF = 3'd3,
    FAIL_GAP = 3'd4
  } status_state_e;

  localparam int unsigned DEFAULT_GAP_TICKS = 4;

  // One extra bit so a zero exit code can be encoded as 2^code_bits blinks.
  function automatic int unsigned blink_cnt_w(input int unsigned code_bits);
    return code_bits + 1;
  endfunction

endpackage

// File: rtl/board_tick_gen.sv
// Free-running prescaler: one-cycle tick on every wrap plus a heartbeat from its MSB.
module board_tick_gen #(
  parameter int unsigned DIV_W = 27
) (
  input  logic clk_gen,
  input  logic rst_n,
  input  logic en,
  output logic tick_o,
  output logic hb_led_o
);

  logic [DIV_W-1:0] cnt;

  // tick_o follows the all-ones count by one cycle, i.e. it marks the wrap.
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      tick_o <= 1'b0;
    end else if (!en) begin
      cnt    <= '0;
      tick_o <= 1'b0;
    end else begin
      cnt    <= cnt + DIV_W'(1);
      tick_o <= (cnt == '1);
    end
  end

  assign hb_led_o = cnt[DIV_W-1];

endmodule

// File: rtl/board_status_ctrl.sv
// Board visibility controller: reset indicator, heartbeat and a status LED bank
// showing a chaser while running, solid on pass, and a blinked exit code on fail.
module board_status_ctrl
  import board_status_pkg::*;
#(
  parameter int unsigned TICK_DIV_W = 27,
  parameter int unsigned NUM_LED    = 4,
  parameter int unsigned EXIT_W     = 32,
  parameter int unsigned CODE_BITS  = 4,
  parameter int unsigned GAP_TICKS  = DEFAULT_GAP_TICKS
) (
  input  logic               clk_gen,
  input  logic               rst_n,
  input  logic               exit_valid_i,
  input  logic [EXIT_W-1:0]  exit_value_i,
  output logic               rst_led_o,
  output logic               hb_led_o,
  output logic [NUM_LED-1:0] status_led_o,
  output logic               exit_latched_o,
  output logic               exit_value_o,
  output logic               tick_o
);

  localparam int unsigned BLINK_W  = blink_cnt_w(CODE_BITS);
  localparam int unsigned GAP_W    = $clog2(GAP_TICKS + 1);
  localparam int unsigned IDX_W    = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
  // With a single lane the index just toggles 0/1, which turns the lane on/off.
  localparam int unsigned LAST_IDX = (NUM_LED > 1) ? NUM_LED - 1 : 1;

  logic                 rst_meta;
  logic                 rst_sync_n;
  status_state_e        state;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_adv;
  logic [BLINK_W-1:0]   blink_cnt;
  logic [BLINK_W-1:0]   burst_len;
  logic [BLINK_W-1:0]   burst_n;
  logic [GAP_W-1:0]     gap_cnt;
  logic [CODE_BITS-1:0] exit_code;
  logic                 capture;
  logic                 exit_is_zero;

  function automatic logic [NUM_LED-1:0] run_leds(input logic [IDX_W-1:0] i);
    return NUM_LED'(1) << i;
  endfunction

  // Two-flop release synchroniser; assertion stays asynchronous.
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  assign rst_led_o = rst_sync_n;

  board_tick_gen #(
    .DIV_W (TICK_DIV_W)
  ) u_tick_gen (
    .clk_gen  (clk_gen),
    .rst_n    (rst_n),
    .en       (rst_sync_n),
    .tick_o   (tick_o),
    .hb_led_o (hb_led_o)
  );

  assign capture      = exit_valid_i & ~exit_latched_o;
  assign exit_is_zero = (exit_value_i == '0);
  assign exit_code    = exit_value_i[CODE_BITS-1:0];
  assign burst_n      = (exit_code == '0) ? {1'b1, {CODE_BITS{1'b0}}} : {1'b0, exit_code};
  assign idx_adv      = (idx == IDX_W'(LAST_IDX)) ? '0 : idx + IDX_W'(1);

  // Status FSM; a capture takes priority over a coincident tick.
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      idx            <= '0;
      blink_cnt      <= '0;
      burst_len      <= '0;
      gap_cnt        <= '0;
      status_led_o   <= '0;
      exit_latched_o <= 1'b0;
      exit_value_o   <= 1'b0;
    end else if (!rst_sync_n) begin
      state          <= RUN;
      idx            <= '0;
      blink_cnt      <= '0;
      burst_len      <= '0;
      gap_cnt        <= '0;
      status_led_o   <= '0;
      exit_latched_o <= 1'b0;
      exit_value_o   <= 1'b0;
    end else if (capture) begin
      exit_latched_o <= 1'b1;
      exit_value_o   <= exit_value_i[0];
      burst_len      <= burst_n;
      blink_cnt      <= burst_n;
      gap_cnt        <= '0;
      status_led_o   <= '1;
      state          <= exit_is_zero ? PASS : FAIL_ON;
    end else begin
      case (state)
        RUN: begin
          if (tick_o) begin
            idx <= idx_adv;
          end
          status_led_o <= run_leds(tick_o ? idx_adv : idx);
        end
        PASS: begin
          status_led_o <= '1;
        end
        FAIL_ON: begin
          if (tick_o) begin
            state        <= FAIL_OFF;
            status_led_o <= '0;
          end
        end
        FAIL_OFF: begin
          if (tick_o) begin
            if (blink_cnt > BLINK_W'(1)) begin
              blink_cnt    <= blink_cnt - BLINK_W'(1);
              state        <= FAIL_ON;
              status_led_o <= '1;
            end else begin
              blink_cnt <= '0;
              gap_cnt   <= GAP_W'(GAP_TICKS);
              state     <= FAIL_GAP;
            end
          end
        end
        FAIL_GAP: begin
          if (tick_o) begin
            if (gap_cnt <= GAP_W'(1)) begin
              gap_cnt      <= '0;
              blink_cnt    <= burst_len;
              state        <= FAIL_ON;
              status_led_o <= '1;
            end else begin
              gap_cnt <= gap_cnt - GAP_W'(1);
            end
          end
        end
        default: begin
          state        <= RUN;
          status_led_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_status_ctrl.sv
// Scoreboard bench for board_status_ctrl: LED changes are checked for value and cycle.
module tb_board_status_ctrl;

  localparam int unsigned TICK_DIV_W = 4;
  localparam int unsigned NUM_LED    = 4;
  localparam int unsigned EXIT_W     = 32;
  localparam int unsigned CODE_BITS  = 4;
  localparam int unsigned GAP_TICKS  = 4;
  localparam int          PERIOD     = 16;

  logic               clk_gen = 1'b0;
  logic               rst_n = 1'b0;
  logic               exit_valid_i = 1'b0;
  logic [EXIT_W-1:0]  exit_value_i = '0;
  logic               rst_led_o;
  logic               hb_led_o;
  logic [NUM_LED-1:0] status_led_o;
  logic               exit_latched_o;
  logic               exit_value_o;
  logic               tick_o;

  always #5 clk_gen = ~clk_gen;

  board_status_ctrl #(
    .TICK_DIV_W (TICK_DIV_W),
    .NUM_LED    (NUM_LED),
    .EXIT_W     (EXIT_W),
    .CODE_BITS  (CODE_BITS),
    .GAP_TICKS  (GAP_TICKS)
  ) dut (
    .clk_gen        (clk_gen),
    .rst_n          (rst_n),
    .exit_valid_i   (exit_valid_i),
    .exit_value_i   (exit_value_i),
    .rst_led_o      (rst_led_o),
    .hb_led_o       (hb_led_o),
    .status_led_o   (status_led_o),
    .exit_latched_o (exit_latched_o),
    .exit_value_o   (exit_value_o),
    .tick_o         (tick_o)
  );

  typedef struct {
    logic [NUM_LED-1:0] led;
    int                 at;
  } sb_item_t;

  sb_item_t           sb_q[$];
  int                 cyc = 0;
  int                 rk = 0;
  int                 n_checks = 0;
  int                 n_errors = 0;
  logic [NUM_LED-1:0] mon_prev = '0;

  always @(posedge clk_gen) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic void push(input logic [NUM_LED-1:0] led, input int at);
    sb_item_t it;
    it.led = led;
    it.at  = at;
    sb_q.push_back(it);
  endfunction

  // First edge after e at which the FSM acts on a tick (tick_o set at rk+16m).
  function automatic int next_react(input int e);
    if (e < rk + PERIOD + 1) return rk + PERIOD + 1;
    return rk + 1 + PERIOD * ((e - rk - 1) / PERIOD + 1);
  endfunction

  // Expected blink bursts for a fail code of n blinks captured at edge e.
  function automatic int push_fail(input int e, input int n, input int bursts);
    int base;
    int per;
    base = next_react(e) - PERIOD;
    per  = PERIOD * (2 * n + int'(GAP_TICKS));
    for (int j = 0; j < bursts; j++) begin
      for (int i = 0; i < n; i++) begin
        int b;
        b = base + j * per + 2 * PERIOD * i;
        push('1, (j == 0 && i == 0) ? e : b);
        push('0, b + PERIOD);
      end
    end
    return base + bursts * per;
  endfunction

  // Every LED change must match the head of the scoreboard in value and cycle.
  always @(negedge clk_gen) begin : mon
    sb_item_t it;
    if (status_led_o !== mon_prev) begin
      if (sb_q.size() == 0) begin
        check("led_extra", 32'(status_led_o), 32'(mon_prev));
      end else begin
        it = sb_q.pop_front();
        check("led_val", 32'(status_led_o), 32'(it.led));
        check("led_at", 32'(cyc), 32'(it.at));
      end
      mon_prev = status_led_o;
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk_gen);
  endtask

  // Called on a negedge; the value is sampled at the following posedge.
  task automatic pulse_exit(input logic [EXIT_W-1:0] v);
    exit_valid_i = 1'b1;
    exit_value_i = v;
    @(negedge clk_gen);
    exit_valid_i = 1'b0;
  endtask

  task automatic apply_reset(input bit led_was_on);
    @(posedge clk_gen);
    #2;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    if (led_was_on) push('0, cyc);
    rst_n = 1'b0;
    #1;
    check("arst_rst_led", 32'(rst_led_o), 32'd0);
    check("arst_hb", 32'(hb_led_o), 32'd0);
    check("arst_status", 32'(status_led_o), 32'd0);
    check("arst_latched", 32'(exit_latched_o), 32'd0);
    check("arst_value", 32'(exit_value_o), 32'd0);
    check("arst_tick", 32'(tick_o), 32'd0);
    repeat (3) @(negedge clk_gen);
  endtask

  task automatic release_reset();
    @(negedge clk_gen);
    rst_n = 1'b1;
    rk = cyc + 2;
    push(4'b0001, rk + 1);
    @(negedge clk_gen);
    check("rst_sync_lo", 32'(rst_led_o), 32'd0);
    @(negedge clk_gen);
    check("rst_sync_hi", 32'(rst_led_o), 32'd1);
  endtask

  initial begin : main
    int e;
    int t_end;

    repeat (3) @(negedge clk_gen);
    check("rst_rst_led", 32'(rst_led_o), 32'd0);
    check("rst_hb", 32'(hb_led_o), 32'd0);
    check("rst_status", 32'(status_led_o), 32'd0);
    check("rst_latched", 32'(exit_latched_o), 32'd0);
    check("rst_value", 32'(exit_value_o), 32'd0);
    check("rst_tick", 32'(tick_o), 32'd0);

    // Chaser, heartbeat and tick spacing after release.
    release_reset();
    push(4'b0010, rk + 17);
    push(4'b0100, rk + 33);
    push(4'b1000, rk + 49);
    push(4'b0001, rk + 65);
    wait_until(rk + 7);  check("hb_lo", 32'(hb_led_o), 32'd0);
    wait_until(rk + 8);  check("hb_hi", 32'(hb_led_o), 32'd1);
    wait_until(rk + 15); check("tick_pre", 32'(tick_o), 32'd0);
    wait_until(rk + 16); check("tick_1", 32'(tick_o), 32'd1);
    wait_until(rk + 17); check("tick_post", 32'(tick_o), 32'd0);
    wait_until(rk + 31); check("tick_pre2", 32'(tick_o), 32'd0);
    wait_until(rk + 32); check("tick_2", 32'(tick_o), 32'd1);
    wait_until(rk + 70);

    // Pass: solid LEDs, later exit pulses ignored.
    e = cyc + 1;
    push('1, e);
    pulse_exit(32'h0);
    check("pass_latched", 32'(exit_latched_o), 32'd1);
    check("pass_value", 32'(exit_value_o), 32'd0);
    wait_until(e + 40);
    pulse_exit(32'h5);
    check("pass_ign_latched", 32'(exit_latched_o), 32'd1);
    check("pass_ign_value", 32'(exit_value_o), 32'd0);
    wait_until(e + 80);
    check("pass_hold", 32'(status_led_o), 32'hF);
    apply_reset(1'b1);

    // Fail code 3: three blinks then four dark ticks, repeating.
    release_reset();
    wait_until(rk + 5);
    e = cyc + 1;
    t_end = push_fail(e, 3, 4);
    pulse_exit(32'h13);
    check("f3_latched", 32'(exit_latched_o), 32'd1);
    check("f3_value", 32'(exit_value_o), 32'd1);
    wait_until(t_end - 10);
    apply_reset(1'b0);

    // Fail with zero code bits: bursts of 16 blinks.
    release_reset();
    wait_until(rk + 5);
    e = cyc + 1;
    t_end = push_fail(e, 16, 2);
    pulse_exit(32'h20);
    check("f0_latched", 32'(exit_latched_o), 32'd1);
    check("f0_value", 32'(exit_value_o), 32'd0);
    wait_until(t_end - 10);
    apply_reset(1'b0);

    // Capture in the tick cycle: chaser must not advance, FAIL_ON next cycle.
    release_reset();
    push(4'b0010, rk + 17);
    wait_until(rk + 32);
    check("sim_tick", 32'(tick_o), 32'd1);
    e = cyc + 1;
    push('1, e);
    push('0, e + PERIOD);
    pulse_exit(32'h2);
    check("sim_latched", 32'(exit_latched_o), 32'd1);
    check("sim_value", 32'(exit_value_o), 32'd0);
    wait_until(e + 20);
    apply_reset(1'b0);

    // Fresh run after a mid-burst reset.
    release_reset();
    push(4'b0010, rk + 17);
    wait_until(rk + 20);
    check("rerun_latched", 32'(exit_latched_o), 32'd0);
    check("rerun_value", 32'(exit_value_o), 32'd0);
    wait_until(rk + 25);
    check("sb_left", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
